// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared encodings for the pipelined MIPS control path:
//               opcode/funct values, ALU operation codes, the per-stage
//               control word (ctrl_t) and the bubble constant.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // --------------------------------------------------------------------------
  // Instruction field encodings (instr[31:26] and instr[5:0])
  // --------------------------------------------------------------------------
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_and   = 6'b100100;
  localparam logic [5:0] c_fn_or    = 6'b100101;
  localparam logic [5:0] c_fn_slt   = 6'b101010;

  // --------------------------------------------------------------------------
  // ALU operation codes
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_alu_and  = 3'b000;
  localparam logic [2:0] c_alu_or   = 3'b001;
  localparam logic [2:0] c_alu_add  = 3'b010;
  localparam logic [2:0] c_alu_sub  = 3'b110;
  localparam logic [2:0] c_alu_slt  = 3'b111;

  typedef enum logic [2:0] {
    ALU_AND = c_alu_and,
    ALU_OR  = c_alu_or,
    ALU_ADD = c_alu_add,
    ALU_SUB = c_alu_sub,
    ALU_SLT = c_alu_slt
  } aluop_t;

  // --------------------------------------------------------------------------
  // Control word carried down the pipeline, one per stage register
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic   valid;
    logic   regwrite;
    logic   memtoreg;
    logic   memwrite;
    logic   branch;
    logic   alusrc;
    logic   regdst;
    aluop_t alucontrol;
  } ctrl_t;

  // A bubble is an all-zero control word; ALU_AND encodes as 3'b000.
  localparam ctrl_t CTRL_BUBBLE = '{
    valid:      1'b0,
    regwrite:   1'b0,
    memtoreg:   1'b0,
    memwrite:   1'b0,
    branch:     1'b0,
    alusrc:     1'b0,
    regdst:     1'b0,
    alucontrol: ALU_AND
  };

  // Replace a control word with a bubble when the instruction is killed.
  function automatic ctrl_t squash(input logic kill, input ctrl_t ctrl);
    return kill ? CTRL_BUBBLE : ctrl;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_controller_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decoder
// Description : Combinational DEC-stage decoder. Maps opcode/funct to the
//               control word entering EXE, and flags jumps and illegal
//               encodings. Jumps and illegal instructions produce a bubble
//               control word so they never write state downstream.
// Ports       : i_opcode  [5:0] instr[31:26]
//               i_funct   [5:0] instr[5:0]
//               o_ctrl    ctrl_t decoded control word (bubble if none)
//               o_jump    j instruction in DEC
//               o_illegal unknown opcode, or R-type with unknown funct
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_jump,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_jump    = 1'b0;
    o_illegal = 1'b0;

    case (i_opcode)
      c_op_rtype: begin
        o_ctrl.valid    = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
        case (i_funct)
          c_fn_add: o_ctrl.alucontrol = ALU_ADD;
          c_fn_sub: o_ctrl.alucontrol = ALU_SUB;
          c_fn_and: o_ctrl.alucontrol = ALU_AND;
          c_fn_or:  o_ctrl.alucontrol = ALU_OR;
          c_fn_slt: o_ctrl.alucontrol = ALU_SLT;
          default: begin
            // Unknown funct: drop the partially built word entirely.
            o_ctrl    = CTRL_BUBBLE;
            o_illegal = 1'b1;
          end
        endcase
      end

      c_op_lw: begin
        o_ctrl.valid      = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end

      c_op_sw: begin
        o_ctrl.valid      = 1'b1;
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end

      c_op_beq: begin
        o_ctrl.valid      = 1'b1;
        o_ctrl.branch     = 1'b1;
        o_ctrl.alucontrol = ALU_SUB;
      end

      c_op_addi: begin
        o_ctrl.valid      = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end

      // The jump is completed by the datapath in DEC; nothing travels on.
      c_op_j: o_jump = 1'b1;

      default: o_illegal = 1'b1;
    endcase
  end

endmodule : ctrl_decoder
`default_nettype wire

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipe_controller
// Description : Pipelined MIPS control path. Decodes in DEC and carries the
//               control word through EXE/MEM/WB with a valid bit per stage.
//               Handles stall bubbles, self-flush on a taken branch (resolved
//               in EXE or MEM), jump/illegal decode and a retire counter.
// Parameters  : ALUCTRL_W  width of alucontrol_EXE (codes zero-extended)
//               BR_IN_EXE  0: branch resolved in MEM, 1: resolved in EXE
//               CNT_W      width of the retired-instruction counter
// Ports       : clk, reset (async, active-high)
//               stall            hazard unit holds DEC, bubble into EXE
//               opcode, funct    DEC instruction fields
//               zero_BR          ALU zero of the branch-resolve stage
//               jump_DEC, illegal_DEC, flush_DEC   combinational DEC flags
//               *_EXE, *_MEM, *_WB                 registered stage controls
//               pcsrc            taken branch (combinational)
//               valid_EXE/MEM/WB stage holds a real instruction
//               retired          valid instructions that left WB
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int BR_IN_EXE = 0,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero_BR,
  output logic                 jump_DEC,
  output logic                 illegal_DEC,
  output logic                 alusrc_EXE,
  output logic                 regdst_EXE,
  output logic [ALUCTRL_W-1:0] alucontrol_EXE,
  output logic                 memtoreg_EXE,
  output logic                 regwrite_EXE,
  output logic                 regwrite_MEM,
  output logic                 memwrite_MEM,
  output logic                 regwrite_WB,
  output logic                 memtoreg_WB,
  output logic                 pcsrc,
  output logic                 flush_DEC,
  output logic                 valid_EXE,
  output logic                 valid_MEM,
  output logic                 valid_WB,
  output logic [CNT_W-1:0]     retired
);

  // --------------------------------------------------------------------------
  // DEC stage decode
  // --------------------------------------------------------------------------
  ctrl_t w_dec_ctrl;
  logic  w_jump;
  logic  w_illegal;

  ctrl_decoder u_decoder (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_ctrl    (w_dec_ctrl),
    .o_jump    (w_jump),
    .o_illegal (w_illegal)
  );

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  ctrl_t            r_exe;
  ctrl_t            r_mem;
  ctrl_t            r_wb;
  logic [CNT_W-1:0] r_retired;

  // --------------------------------------------------------------------------
  // Branch resolution and kill selection
  // --------------------------------------------------------------------------
  logic w_pcsrc;
  logic w_kill_mem;

  generate
    if (BR_IN_EXE != 0) begin : g_br_exe
      // Resolving in EXE: only the instruction currently in DEC is younger.
      assign w_pcsrc    = r_exe.branch & r_exe.valid & zero_BR;
      assign w_kill_mem = 1'b0;
    end else begin : g_br_mem
      // Resolving in MEM: the instruction leaving EXE is also on the wrong
      // path, so it must not reach MEM as a real instruction.
      assign w_pcsrc    = r_mem.branch & r_mem.valid & zero_BR;
      assign w_kill_mem = w_pcsrc;
    end
  endgenerate

  // A taken branch always bubbles EXE, so it covers the stall case too.
  logic  w_kill_exe;
  ctrl_t w_exe_next;
  ctrl_t w_mem_next;

  assign w_kill_exe = w_pcsrc | stall;
  assign w_exe_next = squash(w_kill_exe, w_dec_ctrl);
  assign w_mem_next = squash(w_kill_mem, r_exe);

  // --------------------------------------------------------------------------
  // Pipeline advance and retire counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exe     <= CTRL_BUBBLE;
      r_mem     <= CTRL_BUBBLE;
      r_wb      <= CTRL_BUBBLE;
      r_retired <= '0;
    end else begin
      r_exe <= w_exe_next;
      r_mem <= w_mem_next;
      r_wb  <= r_mem;
      // Free-running count; wraps silently at the counter width.
      if (r_wb.valid) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign jump_DEC       = w_jump;
  assign illegal_DEC    = w_illegal;
  assign pcsrc          = w_pcsrc;
  assign flush_DEC      = w_pcsrc | w_jump;

  assign alusrc_EXE     = r_exe.alusrc;
  assign regdst_EXE     = r_exe.regdst;
  assign alucontrol_EXE = ALUCTRL_W'(r_exe.alucontrol);
  assign memtoreg_EXE   = r_exe.memtoreg;
  assign regwrite_EXE   = r_exe.regwrite;
  assign valid_EXE      = r_exe.valid;

  assign regwrite_MEM   = r_mem.regwrite;
  assign memwrite_MEM   = r_mem.memwrite;
  assign valid_MEM      = r_mem.valid;

  assign regwrite_WB    = r_wb.regwrite;
  assign memtoreg_WB    = r_wb.memtoreg;
  assign valid_WB       = r_wb.valid;

  assign retired        = r_retired;

  // WB only publishes write-back controls; the remaining fields ride along
  // in the struct so the three stage registers stay uniform.
  logic w_unused_wb;
  assign w_unused_wb = ^{r_wb.memwrite, r_wb.branch, r_wb.alusrc,
                         r_wb.regdst, r_wb.alucontrol};

endmodule : pipe_controller
`default_nettype wire

// File: tb/tb_pipe_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_controller
// Description : Self-checking bench for pipe_controller. Two instances run
//               side by side on the same instruction stream: one resolving
//               branches in MEM (32-bit counter), one in EXE (4-bit counter,
//               4-bit alucontrol). A reference model tracks each pipeline as
//               an array of in-flight instruction records.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // In-flight instruction record: what each stage should publish.
  typedef struct packed {
    logic       v, rw, m2r, mw, br, asrc, rdst;
    logic [2:0] alu;
  } ent_t;

  logic       clk, reset, stall, zero_br0, zero_br1;
  logic [5:0] opcode, funct;

  logic       d0_jump, d0_illegal, d0_asrc_exe, d0_rdst_exe, d0_m2r_exe, d0_rw_exe;
  logic       d0_rw_mem, d0_mw_mem, d0_rw_wb, d0_m2r_wb, d0_pcsrc, d0_flush;
  logic       d0_v_exe, d0_v_mem, d0_v_wb;
  logic [2:0] d0_alu_exe;
  logic [31:0] d0_retired;

  logic       d1_jump, d1_illegal, d1_asrc_exe, d1_rdst_exe, d1_m2r_exe, d1_rw_exe;
  logic       d1_rw_mem, d1_mw_mem, d1_rw_wb, d1_m2r_wb, d1_pcsrc, d1_flush;
  logic       d1_v_exe, d1_v_mem, d1_v_wb;
  logic [3:0] d1_alu_exe;
  logic [3:0] d1_retired;

  pipe_controller #(.ALUCTRL_W(3), .BR_IN_EXE(0), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
    .zero_BR(zero_br0), .jump_DEC(d0_jump), .illegal_DEC(d0_illegal),
    .alusrc_EXE(d0_asrc_exe), .regdst_EXE(d0_rdst_exe), .alucontrol_EXE(d0_alu_exe),
    .memtoreg_EXE(d0_m2r_exe), .regwrite_EXE(d0_rw_exe), .regwrite_MEM(d0_rw_mem),
    .memwrite_MEM(d0_mw_mem), .regwrite_WB(d0_rw_wb), .memtoreg_WB(d0_m2r_wb),
    .pcsrc(d0_pcsrc), .flush_DEC(d0_flush), .valid_EXE(d0_v_exe),
    .valid_MEM(d0_v_mem), .valid_WB(d0_v_wb), .retired(d0_retired)
  );

  pipe_controller #(.ALUCTRL_W(4), .BR_IN_EXE(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .funct(funct),
    .zero_BR(zero_br1), .jump_DEC(d1_jump), .illegal_DEC(d1_illegal),
    .alusrc_EXE(d1_asrc_exe), .regdst_EXE(d1_rdst_exe), .alucontrol_EXE(d1_alu_exe),
    .memtoreg_EXE(d1_m2r_exe), .regwrite_EXE(d1_rw_exe), .regwrite_MEM(d1_rw_mem),
    .memwrite_MEM(d1_mw_mem), .regwrite_WB(d1_rw_wb), .memtoreg_WB(d1_m2r_wb),
    .pcsrc(d1_pcsrc), .flush_DEC(d1_flush), .valid_EXE(d1_v_exe),
    .valid_MEM(d1_v_mem), .valid_WB(d1_v_wb), .retired(d1_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = EXE, 1 = MEM, 2 = WB.
  ent_t        p0[3];
  ent_t        p1[3];
  logic [31:0] ret0;
  logic [3:0]  ret1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction table: what each encoding should do once it reaches EXE.
  function automatic ent_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    ent_t e = '0;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
          FN_SUB: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
          FN_AND: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
          FN_OR:  e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
          FN_SLT: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111};
          default: e = '0;
        endcase
      end
      OP_LW:   e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
      OP_SW:   e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
      OP_BEQ:  e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
      OP_ADDI: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      p0[i] = '0;
      p1[i] = '0;
    end
    ret0 = '0;
    ret1 = '0;
  endtask

  task automatic compare_all(input logic pc0, input logic pc1, input logic jmp, input logic ill);
    check_eq("d0_jump",     d0_jump,     jmp);
    check_eq("d0_illegal",  d0_illegal,  ill);
    check_eq("d0_pcsrc",    d0_pcsrc,    pc0);
    check_eq("d0_flush",    d0_flush,    pc0 | jmp);
    check_eq("d0_asrc_exe", d0_asrc_exe, p0[0].asrc);
    check_eq("d0_rdst_exe", d0_rdst_exe, p0[0].rdst);
    check_eq("d0_alu_exe",  d0_alu_exe,  p0[0].alu);
    check_eq("d0_m2r_exe",  d0_m2r_exe,  p0[0].m2r);
    check_eq("d0_rw_exe",   d0_rw_exe,   p0[0].rw);
    check_eq("d0_v_exe",    d0_v_exe,    p0[0].v);
    check_eq("d0_rw_mem",   d0_rw_mem,   p0[1].rw);
    check_eq("d0_mw_mem",   d0_mw_mem,   p0[1].mw);
    check_eq("d0_v_mem",    d0_v_mem,    p0[1].v);
    check_eq("d0_rw_wb",    d0_rw_wb,    p0[2].rw);
    check_eq("d0_m2r_wb",   d0_m2r_wb,   p0[2].m2r);
    check_eq("d0_v_wb",     d0_v_wb,     p0[2].v);
    check_eq("d0_retired",  d0_retired,  ret0);
    check_eq("d1_jump",     d1_jump,     jmp);
    check_eq("d1_illegal",  d1_illegal,  ill);
    check_eq("d1_pcsrc",    d1_pcsrc,    pc1);
    check_eq("d1_flush",    d1_flush,    pc1 | jmp);
    check_eq("d1_asrc_exe", d1_asrc_exe, p1[0].asrc);
    check_eq("d1_rdst_exe", d1_rdst_exe, p1[0].rdst);
    check_eq("d1_alu_exe",  d1_alu_exe,  {1'b0, p1[0].alu});
    check_eq("d1_m2r_exe",  d1_m2r_exe,  p1[0].m2r);
    check_eq("d1_rw_exe",   d1_rw_exe,   p1[0].rw);
    check_eq("d1_v_exe",    d1_v_exe,    p1[0].v);
    check_eq("d1_rw_mem",   d1_rw_mem,   p1[1].rw);
    check_eq("d1_mw_mem",   d1_mw_mem,   p1[1].mw);
    check_eq("d1_v_mem",    d1_v_mem,    p1[1].v);
    check_eq("d1_rw_wb",    d1_rw_wb,    p1[2].rw);
    check_eq("d1_m2r_wb",   d1_m2r_wb,   p1[2].m2r);
    check_eq("d1_v_wb",     d1_v_wb,     p1[2].v);
    check_eq("d1_retired",  d1_retired,  ret1);
  endtask

  // One clock: drive DEC inputs, check everything, then advance the model.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic st,
                      input logic z0, input logic z1);
    ent_t dec;
    ent_t n0[3];
    ent_t n1[3];
    logic pc0, pc1, jmp, ill;
    @(negedge clk);
    opcode = op; funct = fn; stall = st; zero_br0 = z0; zero_br1 = z1;
    #1;
    dec = ref_decode(op, fn);
    jmp = (op == OP_J);
    ill = !jmp && !dec.v;
    pc0 = p0[1].v & p0[1].br & z0;   // MEM-resolving instance
    pc1 = p1[0].v & p1[0].br & z1;   // EXE-resolving instance
    compare_all(pc0, pc1, jmp, ill);
    // Anything younger than a taken branch is discarded.
    n0[2] = p0[1];
    n0[1] = pc0 ? ent_t'('0) : p0[0];
    n0[0] = (pc0 | st) ? ent_t'('0) : dec;
    n1[2] = p1[1];
    n1[1] = p1[0];
    n1[0] = (pc1 | st) ? ent_t'('0) : dec;
    @(posedge clk);
    if (p0[2].v) ret0 = ret0 + 32'd1;
    if (p1[2].v) ret1 = ret1 + 4'd1;
    p0 = n0;
    p1 = n1;
  endtask

  task automatic random_steps(input int n);
    logic [5:0] op, fn;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_BEQ;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = 6'($urandom);
        default: op = OP_R;
      endcase
      case ($urandom_range(0, 5))
        0: fn = FN_ADD;
        1: fn = FN_SUB;
        2: fn = FN_AND;
        3: fn = FN_OR;
        4: fn = FN_SLT;
        default: fn = 6'($urandom);
      endcase
      step(op, fn, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; opcode = OP_BAD; funct = 6'd0;
    zero_br0 = 1'b0; zero_br1 = 1'b0;
    clear_model();
    #1;
    check_eq("rst_v_exe0",   d0_v_exe,   1'b0);
    check_eq("rst_v_mem0",   d0_v_mem,   1'b0);
    check_eq("rst_v_wb0",    d0_v_wb,    1'b0);
    check_eq("rst_retired0", d0_retired, 32'd0);
    check_eq("rst_retired1", d1_retired, 4'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // lw followed by add, no stalls
    step(OP_LW, 6'd0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t1_lw_m2r_exe", d0_m2r_exe, 1'b1);
    step(OP_R, FN_ADD, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t1_lw_m2r_wb", d0_m2r_wb, 1'b1);
    check_eq("t1_lw_rw_wb", d0_rw_wb, 1'b1);
    step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t1_retired", d0_retired, 32'd2);

    // Taken beq followed by sw and add
    step(OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1);
    step(OP_SW, 6'd0, 1'b0, 1'b1, 1'b1);
    #1 check_eq("t3_d1_sw_killed", d1_v_exe, 1'b0);
    step(OP_R, FN_ADD, 1'b0, 1'b1, 1'b1);
    #1 check_eq("t2_d0_mem_killed", d0_v_mem, 1'b0);
    check_eq("t2_d0_mw_mem", d0_mw_mem, 1'b0);
    check_eq("t2_d0_exe_killed", d0_v_exe, 1'b0);
    for (int i = 0; i < 3; i++) step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);

    // Untaken beq: the sw behind it proceeds
    step(OP_BEQ, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_R, FN_SUB, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t3_sw_mw_mem", d0_mw_mem, 1'b1);
    for (int i = 0; i < 3; i++) step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);

    // addi held by a two-cycle stall
    step(OP_ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
    #1 check_eq("t4_stall_v_exe", d0_v_exe, 1'b0);
    check_eq("t4_stall_rw_exe", d0_rw_exe, 1'b0);
    step(OP_ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
    step(OP_ADDI, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);

    // Illegal opcode and jump
    step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_J, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_R, 6'b111111, 1'b0, 1'b0, 1'b0);

    random_steps(500);

    // Asynchronous reset while an sw sits in MEM
    step(OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_eq("t6_pre_mw_mem0", d0_mw_mem, 1'b1);
    check_eq("t6_pre_mw_mem1", d1_mw_mem, 1'b1);
    #2 reset = 1'b1;
    #1 check_eq("t6_rst_mw_mem0", d0_mw_mem, 1'b0);
    check_eq("t6_rst_mw_mem1", d1_mw_mem, 1'b0);
    check_eq("t6_rst_v_exe0", d0_v_exe, 1'b0);
    check_eq("t6_rst_v_wb1", d1_v_wb, 1'b0);
    check_eq("t6_rst_retired0", d0_retired, 32'd0);
    check_eq("t6_rst_retired1", d1_retired, 4'd0);
    clear_model();
    opcode = OP_BAD;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    random_steps(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_controller
`default_nettype wire
